axi_rd_arb_ctrl: RTL and testbench

AXI_RD_ARB_CTRL -- requirements
Module: axi_rd_arb_ctrl

---
 rtl/axi_rd_arb_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_axi_rd_arb_ctrl.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arb_ctrl.sv
// Three-master AXI read arbiter onto one slave port. A single burst is in flight at a time.
// Fixed priority m0 > m1 > m2, with promotion of masters that keep losing arbitration.
module axi_rd_arb_ctrl #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              m0_arvalid,
    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic [3:0]        m0_arlen,
    output logic              m0_arready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_rresp,
    output logic              m0_rvalid,
    output logic              m0_rlast,
    input  logic              m0_rready,

    input  logic              m1_arvalid,
    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic [3:0]        m1_arlen,
    output logic              m1_arready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_rresp,
    output logic              m1_rvalid,
    output logic              m1_rlast,
    input  logic              m1_rready,

    input  logic              m2_arvalid,
    input  logic [ADDR_W-1:0] m2_araddr,
    input  logic [3:0]        m2_arlen,
    output logic              m2_arready,
    output logic [DATA_W-1:0] m2_rdata,
    output logic [1:0]        m2_rresp,
    output logic              m2_rvalid,
    output logic              m2_rlast,
    input  logic              m2_rready,

    output logic [ADDR_W-1:0] s_araddr,
    output logic [3:0]        s_arlen,
    output logic              s_arvalid,
    input  logic              s_arready,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,
    input  logic              s_rvalid,
    input  logic              s_rlast,
    output logic              s_rready,

    output logic [1:0]        owner,
    output logic              busy,
    output logic              len_err
);

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    localparam logic [2:0] Lim = 3'(STARVE_LIM);

    state_e            state;
    logic [2:0]        starve [3];
    logic [3:0]        beat_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        len_q;

    logic [2:0]        req;
    logic [2:0]        rdy_m;
    logic [ADDR_W-1:0] req_addr [3];
    logic [3:0]        req_len [3];

    logic              win_valid;
    logic [1:0]        win;
    logic [ADDR_W-1:0] win_addr;
    logic [3:0]        win_len;
    logic [2:0]        grant;
    logic [2:0]        sel;
    logic              beat;

    assign req         = {m2_arvalid, m1_arvalid, m0_arvalid};
    assign rdy_m       = {m2_rready, m1_rready, m0_rready};
    assign req_addr[0] = m0_araddr;
    assign req_addr[1] = m1_araddr;
    assign req_addr[2] = m2_araddr;
    assign req_len[0]  = m0_arlen;
    assign req_len[1]  = m1_arlen;
    assign req_len[2]  = m2_arlen;

    // Descending loops so the lowest index is written last; the starved pass overrides.
    always_comb begin
        win_valid = 1'b0;
        win       = 2'd0;
        win_addr  = '0;
        win_len   = '0;
        for (int i = 2; i >= 0; i--) begin
            if (req[i]) begin
                win_valid = 1'b1;
                win       = 2'(i);
                win_addr  = req_addr[i];
                win_len   = req_len[i];
            end
        end
        for (int i = 2; i >= 0; i--) begin
            if (req[i] && (starve[i] >= Lim)) begin
                win      = 2'(i);
                win_addr = req_addr[i];
                win_len  = req_len[i];
            end
        end
    end

    // rst_n gates the grant so arready stays low while reset is held with requests pending.
    always_comb begin
        grant = '0;
        sel   = '0;
        for (int i = 0; i < 3; i++) begin
            grant[i] = rst_n && (state == StIdle) && win_valid && (win == 2'(i));
            sel[i]   = (state == StData) && (owner == 2'(i));
        end
    end

    assign s_arvalid = (state == StAddr);
    assign s_araddr  = addr_q;
    assign s_arlen   = len_q;
    assign s_rready  = |(sel & rdy_m);
    assign busy      = (state != StIdle);
    assign beat      = s_rvalid && s_rready;

    assign m0_arready = grant[0];
    assign m1_arready = grant[1];
    assign m2_arready = grant[2];
    assign m0_rvalid  = sel[0] && s_rvalid;
    assign m1_rvalid  = sel[1] && s_rvalid;
    assign m2_rvalid  = sel[2] && s_rvalid;
    assign m0_rlast   = sel[0] && s_rlast;
    assign m1_rlast   = sel[1] && s_rlast;
    assign m2_rlast   = sel[2] && s_rlast;
    assign m0_rdata   = sel[0] ? s_rdata : '0;
    assign m1_rdata   = sel[1] ? s_rdata : '0;
    assign m2_rdata   = sel[2] ? s_rdata : '0;
    assign m0_rresp   = sel[0] ? s_rresp : 2'b00;
    assign m1_rresp   = sel[1] ? s_rresp : 2'b00;
    assign m2_rresp   = sel[2] ? s_rresp : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            owner    <= 2'd0;
            beat_cnt <= 4'd0;
            len_err  <= 1'b0;
            addr_q   <= '0;
            len_q    <= 4'd0;
            for (int i = 0; i < 3; i++) begin
                starve[i] <= 3'd0;
            end
        end else begin
            len_err <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (win_valid) begin
                        addr_q <= win_addr;
                        len_q  <= win_len;
                        owner  <= win;
                        state  <= StAddr;
                        for (int i = 0; i < 3; i++) begin
                            if (req[i] && (win != 2'(i))) begin
                                starve[i] <= (starve[i] >= Lim) ? Lim : starve[i] + 3'd1;
                            end else begin
                                starve[i] <= 3'd0;
                            end
                        end
                    end
                end
                StAddr: begin
                    if (s_arready) begin
                        state    <= StData;
                        beat_cnt <= 4'd0;
                    end
                end
                StData: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + 4'd1;
                        // Flag a last beat off its expected index, or the expected index without last.
                        len_err  <= s_rlast ^ (beat_cnt == len_q);
                        if (s_rlast) begin
                            state <= StIdle;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_arb_ctrl.sv
// Randomized self-checking bench for axi_rd_arb_ctrl; a slave/master driver plus an
// arbitration model computed directly from the priority and starvation rules.
module tb_axi_rd_arb_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LIM = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]    arv = '0;
    logic [AW-1:0] addr [3];
    logic [3:0]    len [3];
    logic [2:0]    rrdy = 3'b111;
    logic          s_arready = 1'b0;
    logic [DW-1:0] s_rdata = '0;
    logic [1:0]    s_rresp = '0;
    logic          s_rvalid = 1'b0;
    logic          s_rlast = 1'b0;

    logic          m0_arready, m1_arready, m2_arready;
    logic [DW-1:0] m0_rdata, m1_rdata, m2_rdata;
    logic [1:0]    m0_rresp, m1_rresp, m2_rresp;
    logic          m0_rvalid, m1_rvalid, m2_rvalid;
    logic          m0_rlast, m1_rlast, m2_rlast;
    logic [AW-1:0] s_araddr;
    logic [3:0]    s_arlen;
    logic          s_arvalid, s_rready, busy, len_err;
    logic [1:0]    owner;

    logic [2:0]    arrdy, rval, rlst;
    logic [DW-1:0] rd_o [3];
    logic [1:0]    rr_o [3];
    assign arrdy = {m2_arready, m1_arready, m0_arready};
    assign rval  = {m2_rvalid, m1_rvalid, m0_rvalid};
    assign rlst  = {m2_rlast, m1_rlast, m0_rlast};
    assign rd_o[0] = m0_rdata;
    assign rd_o[1] = m1_rdata;
    assign rd_o[2] = m2_rdata;
    assign rr_o[0] = m0_rresp;
    assign rr_o[1] = m1_rresp;
    assign rr_o[2] = m2_rresp;

    int checks = 0;
    int failures = 0;
    int starve_m [3];

    axi_rd_arb_ctrl #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIM(LIM)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_arvalid(arv[0]), .m0_araddr(addr[0]), .m0_arlen(len[0]), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rlast(m0_rlast),
        .m0_rready(rrdy[0]),
        .m1_arvalid(arv[1]), .m1_araddr(addr[1]), .m1_arlen(len[1]), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rlast(m1_rlast),
        .m1_rready(rrdy[1]),
        .m2_arvalid(arv[2]), .m2_araddr(addr[2]), .m2_arlen(len[2]), .m2_arready(m2_arready),
        .m2_rdata(m2_rdata), .m2_rresp(m2_rresp), .m2_rvalid(m2_rvalid), .m2_rlast(m2_rlast),
        .m2_rready(rrdy[2]),
        .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rlast(s_rlast),
        .s_rready(s_rready),
        .owner(owner), .busy(busy), .len_err(len_err)
    );

    task automatic clear_inputs();
        arv = '0;
        rrdy = 3'b111;
        s_arready = 1'b0;
        s_rvalid = 1'b0;
        s_rlast = 1'b0;
        s_rdata = '0;
        s_rresp = '0;
        for (int i = 0; i < 3; i++) begin
            addr[i] = '0;
            len[i] = '0;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_inputs();
        for (int i = 0; i < 3; i++) starve_m[i] = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    // Model arbitration: starved requester first, then plain fixed priority.
    function automatic int model_winner(input logic [2:0] r);
        int w = -1;
        for (int i = 2; i >= 0; i--) if (r[i]) w = i;
        for (int i = 2; i >= 0; i--) if (r[i] && starve_m[i] >= LIM) w = i;
        return w;
    endfunction

    function automatic void model_update(input logic [2:0] r, input int w);
        for (int i = 0; i < 3; i++)
            starve_m[i] = (r[i] && i != w) ? ((starve_m[i] + 1 > LIM) ? LIM : starve_m[i] + 1) : 0;
    endfunction

    function automatic int exp_len_err(input int l, input int n);
        int e = 0;
        for (int b = 0; b < n; b++) if ((b == n - 1) != ((b % 16) == l)) e++;
        return e;
    endfunction

    // Wait for a grant (bounded); on return the handshake has passed and the DUT is in ADDR.
    task automatic wait_grant(output int w, output int lat);
        w = -1;
        lat = -1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (arrdy != 3'b000) begin
                lat = c;
                w = (arrdy == 3'b001) ? 0 : (arrdy == 3'b010) ? 1 : (arrdy == 3'b100) ? 2 : 9;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        if (w >= 0 && w < 3) arv[w] = 1'b0;
    endtask

    // Slave side of one burst. Protocol slips are counted into viol for the caller to judge.
    task automatic serve(input int own, input int stall, input int rstall, input int nbeats,
                         input int abort_at, output logic [AW-1:0] got_addr,
                         output logic [3:0] got_len, output int ar_cyc, output int viol,
                         output int lerr, output int routed);
        viol = 0; lerr = 0; routed = 0; ar_cyc = 0;
        got_addr = '0; got_len = '0;
        for (int k = 0; k <= stall; k++) begin
            s_arready = (k == stall);
            #1;
            if (k == 0) begin
                got_addr = s_araddr;
                got_len = s_arlen;
            end
            if (s_arvalid) ar_cyc++;
            if (s_araddr !== got_addr || s_arlen !== got_len || arrdy !== 3'b000) viol++;
            if (rval !== 3'b000 || s_rready !== 1'b0) viol++;
            @(negedge clk);
        end
        s_arready = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            s_rvalid = 1'b1;
            s_rdata = $urandom;
            s_rresp = 2'($urandom_range(0, 3));
            s_rlast = (b == nbeats - 1);
            if (b == abort_at) begin
                rst_n = 1'b0;
                return;
            end
            if (b == 0) begin
                for (int k = 0; k < rstall; k++) begin
                    rrdy[own] = 1'b0;
                    #1;
                    if (s_rready !== 1'b0 || rval !== 3'(1 << own)) viol++;
                    if (len_err) lerr++;
                    @(negedge clk);
                end
                rrdy[own] = 1'b1;
            end
            #1;
            if (s_rready === 1'b1 && rval === 3'(1 << own) && rd_o[own] === s_rdata
                && rr_o[own] === s_rresp && rlst === (s_rlast ? 3'(1 << own) : 3'b000)
                && arrdy === 3'b000 && s_arvalid === 1'b0 && busy === 1'b1) routed++;
            if (len_err) lerr++;
            @(negedge clk);
        end
        s_rvalid = 1'b0;
        s_rlast = 1'b0;
        #1;
        if (len_err) lerr++;
        if (busy !== 1'b0) viol++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        arv = 3'b111;
        #1;
        checks++;
        if ({arrdy, rval, rlst, s_arvalid, s_rready, busy, owner, len_err} !== 14'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0", {arrdy, rval, rlst, s_arvalid, s_rready,
                     busy, owner, len_err});
        end
        apply_reset();
    endtask

    task automatic test_single();
        int w, lat, ac, v, le, ro;
        logic [AW-1:0] ga;
        logic [3:0] gl;
        apply_reset();
        addr[1] = 32'h1000;
        len[1] = 4'd3;
        arv = 3'b010;
        wait_grant(w, lat);
        checks++;
        if (w !== 1 || lat !== 0) begin
            failures++;
            $display("FAIL single_grant got=%0d lat=%0d exp=1 lat=0", w, lat);
        end
        serve(1, 0, 0, 4, -1, ga, gl, ac, v, le, ro);
        checks++;
        if (ga !== 32'h1000 || gl !== 4'd3 || ac !== 1) begin
            failures++;
            $display("FAIL single_ar got=%h/%0d/%0d exp=1000/3/1", ga, gl, ac);
        end
        checks++;
        if (ro !== 4 || v !== 0 || le !== 0 || owner !== 2'd1) begin
            failures++;
            $display("FAIL single_data routed=%0d viol=%0d lerr=%0d owner=%0d exp=4/0/0/1",
                     ro, v, le, owner);
        end
    endtask

    task automatic test_priority();
        int w, lat, ac, v, le, ro;
        logic [AW-1:0] ga;
        logic [3:0] gl;
        apply_reset();
        addr[0] = 32'hA0; len[0] = 4'd1;
        addr[2] = 32'hC0; len[2] = 4'd2;
        arv = 3'b101;
        wait_grant(w, lat);
        checks++;
        if (w !== 0) begin failures++; $display("FAIL prio_first got=%0d exp=0", w); end
        serve(0, 1, 0, 2, -1, ga, gl, ac, v, le, ro);
        checks++;
        if (ro !== 2 || v !== 0 || ga !== 32'hA0) begin
            failures++;
            $display("FAIL prio_m0_burst routed=%0d viol=%0d addr=%h exp=2/0/a0", ro, v, ga);
        end
        wait_grant(w, lat);
        checks++;
        if (w !== 2 || lat !== 0) begin
            failures++;
            $display("FAIL prio_second got=%0d lat=%0d exp=2 lat=0", w, lat);
        end
        serve(2, 0, 0, 3, -1, ga, gl, ac, v, le, ro);
        checks++;
        if (ro !== 3 || v !== 0 || ga !== 32'hC0 || owner !== 2'd2) begin
            failures++;
            $display("FAIL prio_m2_burst routed=%0d viol=%0d addr=%h owner=%0d", ro, v, ga, owner);
        end
    endtask

    task automatic test_starve();
        int w, lat, ac, v, le, ro;
        int exp_w [5] = '{0, 0, 0, 0, 1};
        logic [AW-1:0] ga;
        logic [3:0] gl;
        apply_reset();
        len[0] = 4'd0;
        len[1] = 4'd0;
        addr[1] = 32'h55;
        arv = 3'b011;
        for (int n = 0; n < 5; n++) begin
            arv[0] = 1'b1;
            wait_grant(w, lat);
            checks++;
            if (w !== exp_w[n]) begin
                failures++;
                $display("FAIL starve_arb%0d got=%0d exp=%0d", n + 1, w, exp_w[n]);
            end
            if (w < 0 || w > 2) break;
            serve(w, 0, 0, 1, -1, ga, gl, ac, v, le, ro);
        end
        arv = '0;
    endtask

    task automatic test_len_err();
        int w, lat, ac, v, le, ro;
        logic [AW-1:0] ga;
        logic [3:0] gl;
        apply_reset();
        len[0] = 4'd3;
        arv = 3'b001;
        wait_grant(w, lat);
        serve(0, 0, 0, 2, -1, ga, gl, ac, v, le, ro);
        checks++;
        if (le !== 1 || v !== 0 || ro !== 2) begin
            failures++;
            $display("FAIL len_err_short pulses=%0d viol=%0d routed=%0d exp=1/0/2", le, v, ro);
        end
        len[0] = 4'd1;
        arv = 3'b001;
        wait_grant(w, lat);
        serve(0, 0, 0, 4, -1, ga, gl, ac, v, le, ro);
        checks++;
        if (le !== 2 || v !== 0) begin
            failures++;
            $display("FAIL len_err_long pulses=%0d viol=%0d exp=2/0", le, v);
        end
    endtask

    task automatic test_reset_mid();
        int w, lat, ac, v, le, ro;
        logic [AW-1:0] ga;
        logic [3:0] gl;
        apply_reset();
        len[0] = 4'd3;
        arv = 3'b001;
        wait_grant(w, lat);
        arv = 3'b111;
        serve(0, 0, 0, 4, 1, ga, gl, ac, v, le, ro);
        #1;
        checks++;
        if ({arrdy, rval, rlst, s_arvalid, s_rready, busy, owner, len_err} !== 14'd0) begin
            failures++;
            $display("FAIL reset_mid got=%b exp=0", {arrdy, rval, rlst, s_arvalid, s_rready,
                     busy, owner, len_err});
        end
        apply_reset();
        addr[2] = 32'hBEEF0;
        len[2] = 4'd2;
        arv = 3'b100;
        wait_grant(w, lat);
        checks++;
        if (w !== 2 || lat !== 0) begin
            failures++;
            $display("FAIL reset_mid_regrant got=%0d lat=%0d exp=2 lat=0", w, lat);
        end
        serve(2, 0, 0, 3, -1, ga, gl, ac, v, le, ro);
        checks++;
        if (ro !== 3 || v !== 0 || le !== 0 || ga !== 32'hBEEF0) begin
            failures++;
            $display("FAIL reset_mid_burst routed=%0d viol=%0d lerr=%0d addr=%h", ro, v, le, ga);
        end
    endtask

    task automatic test_stall();
        int w, lat, ac, v, le, ro;
        logic [AW-1:0] ga;
        logic [3:0] gl;
        apply_reset();
        addr[2] = $urandom;
        len[2] = 4'd1;
        arv = 3'b100;
        wait_grant(w, lat);
        arv = 3'b011;
        serve(2, 5, 3, 2, -1, ga, gl, ac, v, le, ro);
        checks++;
        if (ac !== 6 || ga !== addr[2] || gl !== 4'd1) begin
            failures++;
            $display("FAIL stall_ar cycles=%0d addr=%h len=%0d exp=6/%h/1", ac, ga, gl, addr[2]);
        end
        checks++;
        if (v !== 0 || ro !== 2 || le !== 0) begin
            failures++;
            $display("FAIL stall_r viol=%0d routed=%0d lerr=%0d exp=0/2/0", v, ro, le);
        end
        arv = '0;
    endtask

    task automatic test_random();
        int w, lat, ac, v, le, ro, ew, nb, el;
        logic [2:0] r;
        logic [AW-1:0] ga;
        logic [3:0] gl;
        apply_reset();
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < 3; i++) begin
                if (!arv[i] && $urandom_range(0, 1) == 1) begin
                    addr[i] = $urandom;
                    len[i] = 4'($urandom_range(0, 15));
                    arv[i] = 1'b1;
                end
            end
            if (arv == 3'b000) arv[$urandom_range(0, 2)] = 1'b1;
            r = arv;
            ew = model_winner(r);
            model_update(r, ew);
            wait_grant(w, lat);
            checks++;
            if (w !== ew || lat !== 0) begin
                failures++;
                $display("FAIL rand%0d_grant got=%0d lat=%0d exp=%0d req=%b", it, w, lat, ew, r);
            end
            if (w < 0 || w > 2) break;
            nb = ($urandom_range(0, 3) != 0) ? int'(len[w]) + 1 : $urandom_range(1, 16);
            el = exp_len_err(int'(len[w]), nb);
            serve(w, $urandom_range(0, 3), $urandom_range(0, 2), nb, -1, ga, gl, ac, v, le, ro);
            checks++;
            if (ga !== addr[w] || gl !== len[w] || owner !== 2'(w)) begin
                failures++;
                $display("FAIL rand%0d_ar addr=%h len=%0d owner=%0d exp=%h/%0d/%0d",
                         it, ga, gl, owner, addr[w], len[w], w);
            end
            checks++;
            if (ro !== nb || v !== 0 || le !== el) begin
                failures++;
                $display("FAIL rand%0d_data routed=%0d viol=%0d lerr=%0d exp=%0d/0/%0d",
                         it, ro, v, le, nb, el);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_starve();
        test_len_err();
        test_reset_mid();
        test_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
